sevenseg_scan_ctrl: RTL

Parametrised, time-multiplexed hex display controller for the ALU result panel. Latches a packed word of NUM_DIGITS hex nibbles and scans it onto one shared active-low seven-segment bus with active-low digit enables. Supports dead-time between digits, leading-zero blanking, blink mode and global blanking via Read. It replaces the per-register, single-digit combinational decoders with one sequential block driving any number of digits.

---
 rtl/sevenseg_scan_ctrl_if.sv | 24 ++
 rtl/sevenseg_scan_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Bus bundle between the ALU panel logic and the multiplexed seven-segment driver.
// The master supplies the data and display controls; the slave drives the segment and digit lines.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 3
);
    logic                      Read;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data;
    logic                      lzb;
    logic                      blink;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic                      frame;

    modport master (
        output Read, load, data, lzb, blink,
        input  seg, dig_sel, frame
    );

    modport slave (
        input  Read, load, data, lzb, blink,
        output seg, dig_sel, frame
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed hex display scanner: latches NUM_DIGITS nibbles and drives one shared
// active-low segment bus with active-low digit enables, dead-time, leading-zero blanking and blink.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sevenseg_scan_ctrl_if.slave   bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]          cnt_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic [FC_W-1:0]           fcnt_reg;
    logic                      phase_reg;
    logic [4*NUM_DIGITS-1:0]   data_q_reg;
    logic [6:0]                seg_reg;
    logic [NUM_DIGITS-1:0]     dig_sel_reg;
    logic                      frame_reg;

    logic                      slot_end;
    logic                      wrap;
    logic [NUM_DIGITS-1:0]     upper_zero;
    logic [3:0]                nibble;
    logic                      lz_blank;
    logic                      blank;
    logic [NUM_DIGITS-1:0]     dig_onehot;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h01;
            4'h1: g = 7'h4F;
            4'h2: g = 7'h12;
            4'h3: g = 7'h06;
            4'h4: g = 7'h4C;
            4'h5: g = 7'h24;
            4'h6: g = 7'h20;
            4'h7: g = 7'h0F;
            4'h8: g = 7'h00;
            4'h9: g = 7'h0C;
            4'hA: g = 7'h08;
            4'hB: g = 7'h60;
            4'hC: g = 7'h31;
            4'hD: g = 7'h42;
            4'hE: g = 7'h30;
            default: g = 7'h38;
        endcase
        return g;
    endfunction

    // upper_zero[i]: every nibble from i up to the most significant digit is zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
            assign upper_zero[gi] = ~|data_q_reg[4*NUM_DIGITS-1:4*gi];
        end
    endgenerate

    assign slot_end = (cnt_reg == CNT_MAX);
    assign wrap     = slot_end && (idx_reg == IDX_MAX);

    always_comb begin
        nibble     = 4'h0;
        dig_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                nibble        = data_q_reg[4*i +: 4];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    assign lz_blank = bus.lzb && (idx_reg != '0) && upper_zero[idx_reg];
    assign blank    = !bus.Read || (cnt_reg < DEAD_C) || (bus.blink && phase_reg) || lz_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            fcnt_reg    <= '0;
            phase_reg   <= 1'b0;
            data_q_reg  <= '0;
            seg_reg     <= 7'h7F;
            dig_sel_reg <= '1;
            frame_reg   <= 1'b0;
        end else begin
            if (bus.load) begin
                data_q_reg <= bus.data;
            end

            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            frame_reg <= wrap;

            // Blink phase advances on whole frames so a blink half-period never splits a scan.
            if (wrap) begin
                if (fcnt_reg == FC_MAX) begin
                    fcnt_reg  <= '0;
                    phase_reg <= ~phase_reg;
                end else begin
                    fcnt_reg <= fcnt_reg + 1'b1;
                end
            end

            if (blank) begin
                seg_reg     <= 7'h7F;
                dig_sel_reg <= '1;
            end else begin
                seg_reg     <= glyph(nibble);
                dig_sel_reg <= ~dig_onehot;
            end
        end
    end

    assign bus.seg     = seg_reg;
    assign bus.dig_sel = dig_sel_reg;
    assign bus.frame   = frame_reg;
endmodule
